// File: rtl/mux_scan_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_reg_if
// Description : Channel-input and registered-output bundle for mux_scan_reg.
//               The master side drives the sample lines and controls, and the
//               slave side (the mux) returns the selected data and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_reg_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          ch;
  logic                      valid;
  logic                      wrap;

  modport master (
    output din, en, mode, sel,
    input  dout, ch, valid, wrap
  );

  modport slave (
    input  din, en, mode, sel,
    output dout, ch, valid, wrap
  );
endinterface
`default_nettype wire

// File: rtl/mux_scan_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_reg
// Description : Registered N:1 multiplexer with manual select and an auto-scan
//               sequencer that dwells DWELL enabled cycles on each channel.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_reg #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mux_scan_reg_if.slave bus
);
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  D_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] P_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   N_CH   = (SEL_W+1)'(CHANNELS);

  logic [WIDTH-1:0] chan [CHANNELS];

  // Registered state
  logic [WIDTH-1:0] dout_q, dout_n;
  logic [SEL_W-1:0] ch_q, ch_n;
  logic             valid_q, valid_n;
  logic             wrap_q, wrap_n;
  logic [SEL_W-1:0] p_q, p_n;
  logic [DW_W-1:0]  d_q, d_n;
  logic             mode_q, mode_n;

  // Working values for the current cycle
  logic [SEL_W-1:0] p_eff;
  logic [DW_W-1:0]  d_eff;
  logic [WIDTH-1:0] scan_data;
  logic [WIDTH-1:0] man_data;

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_unpack
      assign chan[k] = bus.din[k*WIDTH +: WIDTH];
    end
  endgenerate

  // Next-state logic: enable gating, manual select and scan sequencing
  always_comb begin
    dout_n    = dout_q;
    ch_n      = ch_q;
    valid_n   = 1'b0;
    wrap_n    = 1'b0;
    p_n       = p_q;
    d_n       = d_q;
    mode_n    = mode_q;
    // Entering scan restarts the sequence at channel 0, dwell 0
    p_eff     = mode_q ? p_q : '0;
    d_eff     = mode_q ? d_q : '0;
    scan_data = '0;
    man_data  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (p_eff == SEL_W'(i)) scan_data = chan[i];
      if (bus.sel == SEL_W'(i)) man_data = chan[i];
    end

    if (bus.en) begin
      mode_n = bus.mode;
      if (bus.mode) begin
        dout_n  = scan_data;
        ch_n    = p_eff;
        valid_n = 1'b1;
        if (d_eff == D_LAST) begin
          d_n    = '0;
          // Explicit wrap keeps p legal when CHANNELS is not a power of two
          p_n    = (p_eff == P_LAST) ? '0 : p_eff + 1'b1;
          wrap_n = (p_eff == P_LAST);
        end else begin
          d_n = d_eff + 1'b1;
          p_n = p_eff;
        end
      end else begin
        p_n = '0;
        d_n = '0;
        if ({1'b0, bus.sel} < N_CH) begin
          dout_n  = man_data;
          ch_n    = bus.sel;
          valid_n = 1'b1;
        end else begin
          dout_n  = '0;
        end
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      p_q     <= '0;
      d_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      dout_q  <= dout_n;
      ch_q    <= ch_n;
      valid_q <= valid_n;
      wrap_q  <= wrap_n;
      p_q     <= p_n;
      d_q     <= d_n;
      mode_q  <= mode_n;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
endmodule
`default_nettype wire

// File: tb/tb_mux_scan_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_reg
// Description : Scoreboard bench for mux_scan_reg. Three instances cover
//               CHANNELS=4/DWELL=2, CHANNELS=3/DWELL=2 and CHANNELS=4/DWELL=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_reg;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;

  always #5 clk = ~clk;

  mux_scan_reg_if #(.WIDTH(1), .CHANNELS(4), .SEL_W(2)) ia ();
  mux_scan_reg_if #(.WIDTH(1), .CHANNELS(3), .SEL_W(2)) ib ();
  mux_scan_reg_if #(.WIDTH(1), .CHANNELS(4), .SEL_W(2)) ic ();

  mux_scan_reg #(.WIDTH(1), .CHANNELS(4), .SEL_W(2), .DWELL(2)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ia.slave));
  mux_scan_reg #(.WIDTH(1), .CHANNELS(3), .SEL_W(2), .DWELL(2)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ib.slave));
  mux_scan_reg #(.WIDTH(1), .CHANNELS(4), .SEL_W(2), .DWELL(1)) dut_c (
    .clk(clk), .rst(rst_c), .bus(ic.slave));

  // Expected record packs {dout, ch[1:0], valid, wrap}
  logic [4:0] qa [$];
  logic [4:0] qb [$];
  logic [4:0] qc [$];
  int errors = 0;
  int checks = 0;
  int step_a = 0, step_b = 0, step_c = 0;

  function automatic logic [4:0] e(input logic d, input logic [1:0] c,
                                   input logic v, input logic w);
    return {d, c, v, w};
  endfunction

  task automatic check(input string name, input int step,
                       input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got dout=%b ch=%0d valid=%b wrap=%b, want dout=%b ch=%0d valid=%b wrap=%b",
               name, step, got[4], got[3:2], got[1], got[0],
               exp[4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Monitors: compare one cycle after each edge that had a vector pushed
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      step_a++;
      check("A", step_a, {ia.dout, ia.ch, ia.valid, ia.wrap}, qa.pop_front());
    end
  end
  always @(posedge clk) begin
    #1;
    if (qb.size() > 0) begin
      step_b++;
      check("B", step_b, {ib.dout, ib.ch, ib.valid, ib.wrap}, qb.pop_front());
    end
  end
  always @(posedge clk) begin
    #1;
    if (qc.size() > 0) begin
      step_c++;
      check("C", step_c, {ic.dout, ic.ch, ic.valid, ic.wrap}, qc.pop_front());
    end
  end

  // Drive one vector on the chosen instance and push its expected response
  task automatic vec(input int inst, input logic r, input logic en,
                     input logic m, input logic [1:0] s, input logic [4:0] x);
    @(negedge clk);
    case (inst)
      0: begin rst_a = r; ia.en = en; ia.mode = m; ia.sel = s; qa.push_back(x); end
      1: begin rst_b = r; ib.en = en; ib.mode = m; ib.sel = s; qb.push_back(x); end
      default: begin rst_c = r; ic.en = en; ic.mode = m; ic.sel = s; qc.push_back(x); end
    endcase
  endtask

  task automatic park(input int inst);
    @(negedge clk);
    case (inst)
      0: begin rst_a = 1'b1; ia.en = 1'b0; end
      1: begin rst_b = 1'b1; ib.en = 1'b0; end
      default: begin rst_c = 1'b1; ic.en = 1'b0; end
    endcase
  endtask

  // Expected scan-order outputs for CHANNELS=4, DWELL=2, din=1010
  logic [1:0] scan_ch [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ia.din = 4'b1010; ia.en = 1'b0; ia.mode = 1'b0; ia.sel = 2'd0;
    ib.din = 3'b110;  ib.en = 1'b0; ib.mode = 1'b0; ib.sel = 2'd0;
    ic.din = 4'b1010; ic.en = 1'b0; ic.mode = 1'b0; ic.sel = 2'd0;
    repeat (2) @(negedge clk);

    // A: manual sweep
    vec(0, 1, 0, 0, 2'd0, e(0, 0, 0, 0));
    vec(0, 0, 1, 0, 2'd0, e(0, 0, 1, 0));
    vec(0, 0, 1, 0, 2'd1, e(1, 1, 1, 0));
    vec(0, 0, 1, 0, 2'd2, e(0, 2, 1, 0));
    vec(0, 0, 1, 0, 2'd3, e(1, 3, 1, 0));
    vec(0, 0, 1, 0, 2'd0, e(0, 0, 1, 0));

    // A: full scan, wrap on the 8th output
    vec(0, 1, 0, 0, 2'd0, e(0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      vec(0, 0, 1, 1, 2'd0, e(scan_ch[i][0], scan_ch[i], 1, (i == 7)));

    // A: enable stall after 3rd output, dwell resumes
    vec(0, 1, 0, 0, 2'd0, e(0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vec(0, 0, 1, 1, 2'd0, e(scan_ch[i][0], scan_ch[i], 1, 0));
    for (int i = 0; i < 3; i++)
      vec(0, 0, 0, 1, 2'd0, e(1, 1, 0, 0));
    vec(0, 0, 1, 1, 2'd0, e(1, 1, 1, 0));
    vec(0, 0, 1, 1, 2'd0, e(0, 2, 1, 0));

    // A: reset mid-scan, then mode switches
    vec(0, 1, 0, 0, 2'd0, e(0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vec(0, 0, 1, 1, 2'd0, e(scan_ch[i][0], scan_ch[i], 1, 0));
    vec(0, 1, 1, 1, 2'd0, e(0, 0, 0, 0));
    vec(0, 0, 1, 1, 2'd0, e(0, 0, 1, 0));
    vec(0, 0, 1, 1, 2'd0, e(0, 0, 1, 0));
    vec(0, 0, 1, 1, 2'd0, e(1, 1, 1, 0));
    vec(0, 0, 1, 0, 2'd3, e(1, 3, 1, 0));
    vec(0, 0, 1, 1, 2'd3, e(0, 0, 1, 0));
    // mode drop while disabled must not register
    vec(0, 0, 0, 0, 2'd3, e(0, 0, 0, 0));
    vec(0, 0, 1, 1, 2'd3, e(0, 0, 1, 0));
    vec(0, 0, 1, 1, 2'd3, e(1, 1, 1, 0));
    park(0);

    // B: out-of-range select, then scan with explicit wrap at channel 2
    vec(1, 1, 0, 0, 2'd0, e(0, 0, 0, 0));
    vec(1, 0, 1, 0, 2'd1, e(1, 1, 1, 0));
    vec(1, 0, 1, 0, 2'd3, e(0, 1, 0, 0));
    vec(1, 0, 1, 0, 2'd2, e(1, 2, 1, 0));
    vec(1, 0, 1, 0, 2'd0, e(0, 0, 1, 0));
    vec(1, 0, 1, 1, 2'd0, e(0, 0, 1, 0));
    vec(1, 0, 1, 1, 2'd0, e(0, 0, 1, 0));
    vec(1, 0, 1, 1, 2'd0, e(1, 1, 1, 0));
    vec(1, 0, 1, 1, 2'd0, e(1, 1, 1, 0));
    vec(1, 0, 1, 1, 2'd0, e(1, 2, 1, 0));
    vec(1, 0, 1, 1, 2'd0, e(1, 2, 1, 1));
    vec(1, 0, 1, 1, 2'd0, e(0, 0, 1, 0));
    park(1);

    // C: DWELL=1, p advances every cycle, wrap on 4th and 8th outputs
    vec(2, 1, 0, 0, 2'd0, e(0, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin
      logic [1:0] c;
      c = 2'(i % 4);
      vec(2, 0, 1, 1, 2'd0, e(c[0], c, 1, (i == 3) || (i == 7)));
    end
    park(2);

    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0",
               qa.size() + qb.size() + qc.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised, registered N:1 multiplexer; generalises the fixed 4:1 gate-level mux.
- Adds a clocked manual-select mode and an auto-scan mode. In auto-scan, an internal sequencer steps through all channels with a programmable dwell time.
- Sits between multi-source sample lines and a single downstream consumer (serialiser, display or probe bus) in the gates project.

Parameters:
- WIDTH, 1, bit width of each channel.
- CHANNELS, 4, number of input channels (2..2**SEL_W).
- SEL_W, 2, width of select and channel-index fields.
- DWELL, 2, clock-enabled cycles spent on each channel in scan mode (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- din  in  CHANNELS*WIDTH  packed channel inputs; channel k = din[k*WIDTH +: WIDTH].
- en  in  1  clock enable for all state.
- mode  in  1  0 = manual select, 1 = auto-scan.
- sel  in  SEL_W  manual channel select, sampled when en=1 and mode=0.
- dout  out  WIDTH  registered selected data.
- ch  out  SEL_W  index of the channel currently presented on dout.
- valid  out  1  dout holds a legal, freshly sampled channel this cycle.
- wrap  out  1  one-cycle pulse marking completion of a full scan.

Behaviour:
- Reset has priority over all other inputs. On a clk edge with rst=1:
  - dout=0, ch=0, valid=0, wrap=0.
  - Internal scan pointer p=0, dwell counter d=0, registered mode mode_q=0.
- All outputs are registered with 1-cycle latency: outputs after edge k reflect inputs sampled at edge k.
- en=0:
  - dout and ch hold; valid<=0; wrap<=0.
  - p, d and mode_q freeze.
- Manual mode (en=1, mode=0):
  - If sel<CHANNELS: dout<=din[sel], ch<=sel, valid<=1.
  - If sel>=CHANNELS: dout<=0, ch holds, valid<=0.
  - wrap<=0. p and d are held at 0.
- Scan mode (en=1, mode=1, mode_q=1):
  - dout<=din[p], ch<=p, valid<=1.
  - If d<DWELL-1: d<=d+1.
  - If d==DWELL-1: d<=0, and p<=(p==CHANNELS-1) ? 0 : p+1.
  - wrap<=1 only when d==DWELL-1 and p==CHANNELS-1; otherwise wrap<=0.
- Mode change (en=1, mode!=mode_q):
  - mode_q<=mode.
  - Entering scan: this cycle is treated as scan with p=0, d=0. dout<=din[0], ch<=0, valid<=1, then d<=1 (or p<=1 if DWELL=1).
  - Leaving scan: manual rules apply immediately; p and d clear to 0.
  - A mode change while en=0 is not registered until en=1.
- DWELL=1: p advances every enabled cycle. wrap pulses every CHANNELS enabled cycles.
- CHANNELS not a power of two: p wraps explicitly at CHANNELS-1 and never reaches an illegal index.
- Reset asserted mid-scan: the next enabled scan cycle restarts from channel 0, dwell 0. No stale wrap is produced.
- din changes mid-dwell: each enabled cycle re-samples din[p]. dout is not latched for the whole dwell.
- Combinational paths: none from inputs to outputs.

Test Plan:
- Manual sweep. WIDTH=1, CHANNELS=4, din=4'b1010 (i0=0, i1=1, i2=0, i3=1), mode=0, en=1, sel=0,1,2,3,0 on successive edges.
  Required: dout=0,1,0,1,0 and ch=0,1,2,3,0, each one cycle after its sel; valid=1 throughout; wrap=0.
- Scan sequence. Same din, DWELL=2; rst for 1 cycle, then mode=1, en=1 for 10 cycles.
  Required: dout=0,0,1,1,0,0,1,1,0,0; ch=0,0,1,1,2,2,3,3,0,0; wrap=1 only on the 8th output cycle.
- Enable stall. Scan as above; en=0 for 3 cycles after the 3rd output.
  Required: dout=1 and ch=1 hold, valid=0, no wrap. After en returns, the next output is dout=1, ch=1, i.e. the dwell resumes with its remaining cycle.
- Out-of-range select. CHANNELS=3, SEL_W=2, manual sel=1 then sel=3.
  Required: after sel=1, dout=din[1], ch=1, valid=1. After sel=3, dout=0, ch stays 1, valid=0.
- Reset mid-scan and mode switch:
  - rst=1 while ch=2. Required: next edge gives dout=0, ch=0, valid=0, wrap=0. Next scan output is ch=0.
  - Separately, switch mode 1->0 with sel=3. Required: next output ch=3. Switch back 0->1: next output ch=0.
- DWELL=1, CHANNELS=4, scan for 9 enabled cycles.
  Required: ch=0,1,2,3,0,1,2,3,0; wrap=1 on the 4th and 8th output cycles only.
